// File: rtl/mux_scan_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mux_scan_controller: steps a mux select across all inputs, samples z at the  |
// | end of each dwell and publishes the assembled word.      Rev 1.0             |
// +-----------------------------------------------------------------------------+
module mux_scan_controller #(
  parameter  int INs   = 5,
  parameter  int DWELL = 1,
  localparam int SW    = (INs > 1) ? $clog2(INs) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           cont,
  input  logic           z,
  output logic [SW-1:0]  s,
  output logic [INs-1:0] data,
  output logic           busy,
  output logic           done,
  output logic           valid
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [DW-1:0]  dwell_cnt;
  logic [SW-1:0]  sel;
  logic [INs-1:0] shadow;
  logic           seg_end;
  logic           scan_end;

  assign seg_end  = (dwell_cnt == DW'(DWELL - 1));
  assign scan_end = (state == ST_SCAN) && seg_end && (sel == SW'(INs - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SCAN;
      ST_SCAN: if (scan_end && !cont) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SCAN);
    s    = sel;
  end

  // The last channel bypasses the shadow so the word is ready on the completion edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= '0;
      dwell_cnt <= '0;
      shadow    <= '0;
      data      <= '0;
      done      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_SCAN) begin
        if (seg_end) begin
          dwell_cnt <= '0;
          for (int i = 0; i < INs; i++) begin
            if (sel == SW'(i)) shadow[i] <= z;
          end
          if (scan_end) begin
            sel   <= '0;
            data  <= {z, shadow[INs-2:0]};
            done  <= 1'b1;
            valid <= 1'b1;
          end else begin
            sel <= sel + 1'b1;
          end
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end else begin
        sel       <= '0;
        dwell_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mux_scan_controller: three controller instances, each feeding a 1-bit mux |
// | model, checked against a time-indexed model of the scan.  Rev 1.0            |
// +-----------------------------------------------------------------------------+
module tb_mux_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance 0: INs=5, DWELL=1
  logic       start_a, cont_a;
  logic [4:0] x_a;
  logic       z_a;
  logic [2:0] s_a;
  logic [4:0] data_a;
  logic       busy_a, done_a, valid_a;

  // Instance 1: INs=5, DWELL=3
  logic       start_b, cont_b;
  logic [4:0] x_b;
  logic       z_b;
  logic [2:0] s_b;
  logic [4:0] data_b;
  logic       busy_b, done_b, valid_b;

  // Instance 2: INs=3, DWELL=2
  logic       start_c, cont_c;
  logic [2:0] x_c;
  logic       z_c;
  logic [1:0] s_c;
  logic [2:0] data_c;
  logic       busy_c, done_c, valid_c;

  assign z_a = x_a[s_a];
  assign z_b = x_b[s_b];
  assign z_c = x_c[s_c];

  mux_scan_controller #(.INs(5), .DWELL(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .cont(cont_a), .z(z_a),
    .s(s_a), .data(data_a), .busy(busy_a), .done(done_a), .valid(valid_a)
  );
  mux_scan_controller #(.INs(5), .DWELL(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .cont(cont_b), .z(z_b),
    .s(s_b), .data(data_b), .busy(busy_b), .done(done_b), .valid(valid_b)
  );
  mux_scan_controller #(.INs(3), .DWELL(2)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .cont(cont_c), .z(z_c),
    .s(s_c), .data(data_c), .busy(busy_c), .done(done_c), .valid(valid_c)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] last_data [3];
  logic        cur_cont  [3];
  logic [4:0]  cur_x     [3];

  logic [31:0] o_s, o_data;
  logic        o_busy, o_done, o_valid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int idx);
    case (idx)
      0: begin o_s = 32'(s_a); o_data = 32'(data_a); o_busy = busy_a; o_done = done_a; o_valid = valid_a; end
      1: begin o_s = 32'(s_b); o_data = 32'(data_b); o_busy = busy_b; o_done = done_b; o_valid = valid_b; end
      default: begin o_s = 32'(s_c); o_data = 32'(data_c); o_busy = busy_c; o_done = done_c; o_valid = valid_c; end
    endcase
  endtask

  task automatic drive(input int idx, input logic st, input logic ct);
    case (idx)
      0: begin start_a = st; cont_a = ct; end
      1: begin start_b = st; cont_b = ct; end
      default: begin start_c = st; cont_c = ct; end
    endcase
  endtask

  task automatic set_x(input int idx, input logic [4:0] v);
    cur_x[idx] = v;
    case (idx)
      0: x_a = v;
      1: x_b = v;
      default: x_c = v[2:0];
    endcase
  endtask

  task automatic kick(input int idx);
    drive(idx, 1'b1, cur_cont[idx]);
    step();
    drive(idx, 1'b0, cur_cont[idx]);
  endtask

  // Entered on the cycle right after the scan's start edge; returns just after its completion edge.
  // Channel i occupies cycles i*dwell .. (i+1)*dwell-1; its bit is whatever x held on the last of them.
  task automatic run_scan(input int idx, input int ins, input int dwell, input bit rand_x,
                          input int cont_k, input bit cont_v, input int start_k, input bit start_hold);
    logic [31:0] exp_word;
    logic [4:0]  xv;
    exp_word = '0;
    for (int k = 0; k < ins * dwell; k++) begin
      if (k == cont_k) cur_cont[idx] = cont_v;
      xv = rand_x ? 5'($urandom) : cur_x[idx];
      set_x(idx, xv);
      drive(idx, start_hold || (k == start_k), cur_cont[idx]);
      if (k % dwell == dwell - 1) exp_word[k / dwell] = xv[k / dwell];
      sample(idx);
      total++;
      if (o_s !== 32'(k / dwell) || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL scan_step inst=%0d k=%0d: s=%0d busy=%b, expected s=%0d busy=1", idx, k, o_s, o_busy, k / dwell);
      end
      total++;
      if (o_data !== last_data[idx] || (k > 0 && o_done !== 1'b0)) begin
        bad++;
        $display("FAIL data_hold inst=%0d k=%0d: data=%h done=%b, expected data=%h done=0", idx, k, o_data, o_done, last_data[idx]);
      end
      step();
    end
    sample(idx);
    total++;
    if (o_done !== 1'b1 || o_data !== exp_word || o_valid !== 1'b1) begin
      bad++;
      $display("FAIL completion inst=%0d: done=%b data=%h valid=%b, expected done=1 data=%h valid=1", idx, o_done, o_data, o_valid, exp_word);
    end
    total++;
    if (o_busy !== cur_cont[idx] || o_s !== 32'd0) begin
      bad++;
      $display("FAIL after_completion inst=%0d: busy=%b s=%0d, expected busy=%b s=0", idx, o_busy, o_s, cur_cont[idx]);
    end
    last_data[idx] = exp_word;
    if (!start_hold) drive(idx, 1'b0, cur_cont[idx]);
  endtask

  task automatic check_idle(input int idx, input string tag);
    sample(idx);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_s !== 32'd0 || o_data !== last_data[idx]) begin
      bad++;
      $display("FAIL %s inst=%0d: busy=%b done=%b s=%0d data=%h, expected busy=0 done=0 s=0 data=%h", tag, idx, o_busy, o_done, o_s, o_data, last_data[idx]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur_cont[i] = 1'b0;
      last_data[i] = '0;
      drive(i, 1'b0, 1'b0);
      set_x(i, 5'b0);
    end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(i);
      total++;
      if (o_s !== 0 || o_data !== 0 || o_busy !== 0 || o_done !== 0 || o_valid !== 0) begin
        bad++;
        $display("FAIL reset_state inst=%0d: s=%0d data=%h busy=%b done=%b valid=%b, expected all 0", i, o_s, o_data, o_busy, o_done, o_valid);
      end
    end
    step();
    check_idle(0, "idle_no_start");
  endtask

  task automatic test_single();
    set_x(0, 5'b10101);
    kick(0);
    run_scan(0, 5, 1, 1'b0, -1, 1'b0, -1, 1'b0);
    total++;
    if (data_a !== 5'b10101) begin
      bad++;
      $display("FAIL single_word: data=%b, expected 10101", data_a);
    end
    step();
    check_idle(0, "single_idle");
    for (int t = 0; t < 3; t++) begin
      kick(0);
      run_scan(0, 5, 1, 1'b1, -1, 1'b0, -1, 1'b0);
      step();
      check_idle(0, "single_rand_idle");
    end
  endtask

  task automatic test_dwell();
    set_x(1, 5'b01100);
    kick(1);
    run_scan(1, 5, 3, 1'b0, -1, 1'b0, -1, 1'b0);
    total++;
    if (data_b !== 5'b01100) begin
      bad++;
      $display("FAIL dwell_word: data=%b, expected 01100", data_b);
    end
    for (int t = 0; t < 2; t++) begin
      step();
      check_idle(1, "dwell_idle");
      kick(1);
      run_scan(1, 5, 3, 1'b1, -1, 1'b0, -1, 1'b0);
    end
    step();
    check_idle(1, "dwell_end_idle");
  endtask

  task automatic test_back_to_back();
    cur_cont[0] = 1'b1;
    set_x(0, 5'b10101);
    kick(0);
    run_scan(0, 5, 1, 1'b0, -1, 1'b0, -1, 1'b0);
    set_x(0, 5'b11111);
    run_scan(0, 5, 1, 1'b0, -1, 1'b0, -1, 1'b0);
    total++;
    if (data_a !== 5'b11111) begin
      bad++;
      $display("FAIL cont_second_word: data=%b, expected 11111", data_a);
    end
    run_scan(0, 5, 1, 1'b1, -1, 1'b0, -1, 1'b0);
    run_scan(0, 5, 1, 1'b1, 1, 1'b0, -1, 1'b0);
    step();
    check_idle(0, "cont_drop_idle");
    cur_cont[2] = 1'b0;
    kick(2);
    run_scan(2, 3, 2, 1'b1, 3, 1'b1, -1, 1'b0);
    run_scan(2, 3, 2, 1'b1, 0, 1'b0, -1, 1'b0);
    step();
    check_idle(2, "cont_raise_idle");
  endtask

  task automatic test_restart_and_reset();
    set_x(0, 5'b10101);
    kick(0);
    for (int k = 0; k < 4; k++) begin
      drive(0, k == 2, 1'b0);
      if (k == 3) reset = 1'b1;
      sample(0);
      total++;
      if (o_s !== 32'(k) || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL no_restart k=%0d: s=%0d busy=%b, expected s=%0d busy=1", k, o_s, o_busy, k);
      end
      step();
    end
    reset = 1'b0;
    drive(0, 1'b0, 1'b0);
    sample(0);
    total++;
    if (o_s !== 0 || o_data !== 0 || o_valid !== 0 || o_busy !== 0 || o_done !== 0) begin
      bad++;
      $display("FAIL mid_scan_reset: s=%0d data=%h valid=%b busy=%b done=%b, expected all 0", o_s, o_data, o_valid, o_busy, o_done);
    end
    for (int i = 0; i < 3; i++) last_data[i] = '0;
  endtask

  task automatic test_non_pow2();
    set_x(2, 5'b00110);
    kick(2);
    run_scan(2, 3, 2, 1'b0, -1, 1'b0, -1, 1'b0);
    total++;
    if (data_c !== 3'b110) begin
      bad++;
      $display("FAIL npow2_word: data=%b, expected 110", data_c);
    end
    step();
    check_idle(2, "npow2_idle");
    kick(2);
    run_scan(2, 3, 2, 1'b1, -1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_start_held();
    step();
    drive(2, 1'b1, 1'b0);
    step();
    run_scan(2, 3, 2, 1'b1, -1, 1'b0, -1, 1'b1);
    step();
    sample(2);
    total++;
    if (o_busy !== 1'b1 || o_s !== 32'd0) begin
      bad++;
      $display("FAIL start_held_rescan: busy=%b s=%0d, expected busy=1 s=0", o_busy, o_s);
    end
    run_scan(2, 3, 2, 1'b1, -1, 1'b0, -1, 1'b0);
    step();
    check_idle(2, "start_held_idle");
  endtask

  initial begin
    test_reset();
    test_single();
    test_dwell();
    test_back_to_back();
    test_restart_and_reset();
    test_non_pow2();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
